cache_fill_ctrl: RTL



---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_arb.sv | 54 +++++
 rtl/cache_fill_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and size helpers for the cache miss/fill controller.
package cache_pkg;

    // Controller states: waiting for work, streaming a block, completion pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bytes in one memory word.
    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    // Byte-offset bits inside one cache block (cleared to form the block base).
    function automatic int offset_bits(input int words, input int data_w);
        return $clog2(words * (data_w / 8));
    endfunction

    // Width of a word index within a block.
    function automatic int idx_w(input int words);
        return $clog2(words);
    endfunction

endpackage

// File: rtl/cache_arb.sv
// Channel arbiter for block misses.
// Build option RR_ARB_EN: round-robin search starting at an internal pointer
// that moves past each completed grant; otherwise fixed priority, lowest
// channel index wins.
module cache_arb #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
`ifdef RR_ARB_EN
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv_i,
    input  logic [CH_W-1:0]   last_gnt_i,
`endif
    input  logic [NUM_CH-1:0] req_i,
    output logic [CH_W-1:0]   gnt_o,
    output logic              gnt_vld_o
);

    logic [CH_W-1:0] start;
    logic [CH_W-1:0] idx;

`ifdef RR_ARB_EN
    logic [CH_W-1:0] ptr_q;

    // Move the search start just past the channel whose fill has completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (adv_i) begin
            ptr_q <= (last_gnt_i == CH_W'(NUM_CH - 1)) ? '0 : last_gnt_i + 1'b1;
        end
    end

    assign start = ptr_q;
`else
    assign start = '0;
`endif

    // Scan from the far end toward start so the channel nearest start wins.
    always_comb begin
        gnt_o     = '0;
        gnt_vld_o = 1'b0;
        idx       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = CH_W'((int'(start) + i) % NUM_CH);
            if (req_i[idx]) begin
                gnt_o     = idx;
                gnt_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss-handling and memory-arbitration controller: arbitrates per-channel
// block misses onto one pipelined memory, streams the returned words into the
// granted cache, and services D-side write-through stores while idle.
// Build option RR_ARB_EN selects round-robin arbitration (default: fixed
// priority, channel 0 first).
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_CH-1:0]                    miss_req,
    input  logic [NUM_CH*ADDR_W-1:0]             miss_addr,
    input  logic                                 wr_req,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [DATA_W-1:0]                    wr_data,
    output logic                                 wr_ack,
    output logic                                 mem_en,
    output logic                                 mem_wr,
    output logic [ADDR_W-1:0]                    mem_addr,
    output logic [DATA_W-1:0]                    mem_wdata,
    input  logic [DATA_W-1:0]                    mem_rdata,
    input  logic                                 mem_rvalid,
    output logic [NUM_CH-1:0]                    fill_we,
    output logic [idx_w(WORDS_PER_BLOCK)-1:0]    fill_idx,
    output logic [DATA_W-1:0]                    fill_data,
    output logic [NUM_CH-1:0]                    fill_done,
    output logic                                 stall
);

    localparam int BYTES_PER_WORD = bytes_per_word(DATA_W);
    localparam int OFFSET_BITS    = offset_bits(WORDS_PER_BLOCK, DATA_W);
    localparam int IDX_W          = idx_w(WORDS_PER_BLOCK);
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFFSET_BITS;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS_PER_BLOCK - 1);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   gnt_q, gnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  iss_q, iss_d;
    logic              iss_done_q, iss_done_d;
    logic [IDX_W-1:0]  rcv_q, rcv_d;

    logic [CH_W-1:0]   arb_gnt;
    logic              arb_vld;
    logic [ADDR_W-1:0] sel_addr;

    cache_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
`ifdef RR_ARB_EN
        .clk        (clk),
        .rst_n      (rst_n),
        .adv_i      (state_q == DONE),
        .last_gnt_i (gnt_q),
`endif
        .req_i      (miss_req),
        .gnt_o      (arb_gnt),
        .gnt_vld_o  (arb_vld)
    );

    assign sel_addr = miss_addr[int'(arb_gnt) * ADDR_W +: ADDR_W];

    // Stall whenever a fill is in flight or any cache is reporting a miss.
    assign stall = (state_q != IDLE) | (|miss_req);

    // State, grant, block base and issue/receive counters.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            base_q     <= '0;
            iss_q      <= '0;
            iss_done_q <= 1'b0;
            rcv_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            base_q     <= base_d;
            iss_q      <= iss_d;
            iss_done_q <= iss_done_d;
            rcv_q      <= rcv_d;
        end
    end

    // Next-state logic and all memory/fill outputs.
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        base_d     = base_q;
        iss_d      = iss_q;
        iss_done_d = iss_done_q;
        rcv_d      = rcv_q;
        wr_ack     = 1'b0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_we    = '0;
        fill_idx   = '0;
        fill_data  = '0;
        fill_done  = '0;

        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    // Stores take the memory port first; misses wait a cycle.
                    mem_en    = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                    wr_ack    = 1'b1;
                end else if (arb_vld) begin
                    gnt_d      = arb_gnt;
                    base_d     = sel_addr & BASE_MASK;
                    iss_d      = '0;
                    iss_done_d = 1'b0;
                    rcv_d      = '0;
                    state_d    = FILL;
                end
            end

            FILL: begin
                // Issue one read per cycle until every word has been requested.
                if (!iss_done_q) begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + ADDR_W'(iss_q) * ADDR_W'(BYTES_PER_WORD);
                    iss_d    = iss_q + 1'b1;
                    if (iss_q == LAST_IDX) begin
                        iss_done_d = 1'b1;
                    end
                end
                // Returned words arrive in order; write each into the granted cache.
                if (mem_rvalid) begin
                    fill_we   = NUM_CH'(1) << gnt_q;
                    fill_idx  = rcv_q;
                    fill_data = mem_rdata;
                    rcv_d     = rcv_q + 1'b1;
                    if (rcv_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                fill_done = NUM_CH'(1) << gnt_q;
                state_d   = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
